// File: rtl/rs_issue_scheduler.sv
// Reservation-station bank controller: lowest-free allocation, CDB wakeup, oldest-first issue.
// Optional macro RS_SCHED_CDB_BYPASS_EN captures a same-cycle CDB tag into a dispatching station.
module rs_issue_scheduler #(
  parameter int REG_STATIONS_WIDTH  = 2,
  parameter int REG_FILE_ADDR_WIDTH = 7
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           dispatch_valid,
  output logic                           dispatch_ready,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] dispatch_rs1,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] dispatch_rs2,
  input  logic                           dispatch_rs1_ready,
  input  logic                           dispatch_rs2_ready,
  output logic                           stat_write_en,
  output logic [REG_STATIONS_WIDTH-1:0]  stat_write_sel,
  input  logic                           cdb_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] cdb_in,
  output logic                           issue_valid,
  input  logic                           issue_ready,
  output logic [REG_STATIONS_WIDTH-1:0]  issue_sel,
  output logic                           stat_clear,
  output logic [REG_STATIONS_WIDTH-1:0]  stat_clear_sel,
  input  logic                           flush,
  output logic                           stat_flush,
  output logic [REG_STATIONS_WIDTH:0]    occupancy
);
  localparam int SW = REG_STATIONS_WIDTH;
  localparam int AW = REG_FILE_ADDR_WIDTH;
  localparam int NS = 2**SW;

  typedef enum logic {IDLE, OFFER} state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [SW:0]           occ_q, occ_d;
  logic [NS-1:0]         valid_q, valid_d;
  logic [NS-1:0]         rdy1_q, rdy1_d;
  logic [NS-1:0]         rdy2_q, rdy2_d;
  logic [AW-1:0]         rs1_q [NS];
  logic [AW-1:0]         rs2_q [NS];
  // older_q[i][j] set means station i was allocated before station j
  logic [NS-1:0][NS-1:0] older_q;

  logic          any_free;
  logic [SW-1:0] free_idx;
  logic [NS-1:0] elig, sel_oh;
  logic          first_any, rest_any;
  logic [SW-1:0] first_idx, rest_idx;
  logic          issue_fire, cdb_hazard, new_rdy1, new_rdy2;

  function automatic logic [SW:0] pick_oldest(input logic [NS-1:0]         mask,
                                              input logic [NS-1:0][NS-1:0] older);
    logic [SW:0] res;
    logic        beaten;
    res = '0;
    for (int i = 0; i < NS; i++) begin
      beaten = 1'b0;
      for (int j = 0; j < NS; j++) begin
        if (mask[j] && older[j][i]) beaten = 1'b1;
      end
      if (mask[i] && !beaten) res = {1'b1, SW'(i)};
    end
    return res;
  endfunction

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_free = 1'b1;
        free_idx = SW'(i);
      end
    end
  end

`ifdef RS_SCHED_CDB_BYPASS_EN
  assign cdb_hazard = 1'b0;
  assign new_rdy1   = dispatch_rs1_ready | (cdb_valid & (dispatch_rs1 == cdb_in));
  assign new_rdy2   = dispatch_rs2_ready | (cdb_valid & (dispatch_rs2 == cdb_in));
`else
  // Without bypass, stall a dispatch that would miss a broadcast of its own pending tag
  assign cdb_hazard = cdb_valid & ((~dispatch_rs1_ready & (dispatch_rs1 == cdb_in)) |
                                   (~dispatch_rs2_ready & (dispatch_rs2 == cdb_in)));
  assign new_rdy1   = dispatch_rs1_ready;
  assign new_rdy2   = dispatch_rs2_ready;
`endif

  assign dispatch_ready = any_free & ~flush & ~cdb_hazard;
  assign stat_write_en  = dispatch_valid & dispatch_ready;
  assign stat_write_sel = free_idx;
  assign issue_valid    = (state_q == OFFER);
  assign issue_sel      = sel_q;
  assign issue_fire     = issue_valid & issue_ready & ~flush;
  assign stat_clear     = issue_fire;
  assign stat_clear_sel = sel_q;
  assign stat_flush     = flush;
  assign occupancy      = occ_q;

  assign elig   = valid_q & rdy1_q & rdy2_q;
  assign sel_oh = {{(NS-1){1'b0}}, 1'b1} << sel_q;
  assign {first_any, first_idx} = pick_oldest(elig, older_q);
  assign {rest_any, rest_idx}   = pick_oldest(elig & ~sel_oh, older_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (first_any) begin
            state_d = OFFER;
            sel_d   = first_idx;
          end
        end
        OFFER: begin
          if (issue_fire) begin
            if (rest_any) sel_d = rest_idx;
            else          state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    for (int i = 0; i < NS; i++) begin
      if (cdb_valid && valid_q[i]) begin
        if (rs1_q[i] == cdb_in) rdy1_d[i] = 1'b1;
        if (rs2_q[i] == cdb_in) rdy2_d[i] = 1'b1;
      end
    end
    if (issue_fire) valid_d[sel_q] = 1'b0;
    if (stat_write_en) begin
      valid_d[free_idx] = 1'b1;
      rdy1_d[free_idx]  = new_rdy1;
      rdy2_d[free_idx]  = new_rdy2;
    end
    if (flush) valid_d = '0;
    occ_d = flush ? '0 : occ_q + (SW+1)'(stat_write_en) - (SW+1)'(issue_fire);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      occ_q   <= '0;
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
    end
  end

  // Tags and age order are only meaningful under valid, so they carry no reset
  always_ff @(posedge clock) begin
    if (stat_write_en) begin
      rs1_q[free_idx] <= dispatch_rs1;
      rs2_q[free_idx] <= dispatch_rs2;
      for (int j = 0; j < NS; j++) begin
        older_q[free_idx][j] <= 1'b0;
        older_q[j][free_idx] <= (SW'(j) != free_idx);
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler with a sequence-number scoreboard checked every cycle.
module tb_rs_issue_scheduler;
  localparam int SW = 2;
  localparam int AW = 7;
  localparam int NS = 4;

  logic          clock;
  logic          reset = 1'b1;
  logic          dispatch_valid, dispatch_ready;
  logic [AW-1:0] dispatch_rs1, dispatch_rs2;
  logic          dispatch_rs1_ready, dispatch_rs2_ready;
  logic          stat_write_en;
  logic [SW-1:0] stat_write_sel;
  logic          cdb_valid;
  logic [AW-1:0] cdb_in;
  logic          issue_valid, issue_ready;
  logic [SW-1:0] issue_sel;
  logic          stat_clear;
  logic [SW-1:0] stat_clear_sel;
  logic          flush, stat_flush;
  logic [SW:0]   occupancy;

  int checks = 0;
  int errors = 0;

  rs_issue_scheduler #(.REG_STATIONS_WIDTH(SW), .REG_FILE_ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_rs1(dispatch_rs1), .dispatch_rs2(dispatch_rs2),
    .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
    .stat_write_en(stat_write_en), .stat_write_sel(stat_write_sel),
    .cdb_valid(cdb_valid), .cdb_in(cdb_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_sel(issue_sel),
    .stat_clear(stat_clear), .stat_clear_sel(stat_clear_sel),
    .flush(flush), .stat_flush(stat_flush), .occupancy(occupancy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: each station remembers its dispatch sequence number; smaller means older.
  bit            m_valid [NS] = '{default: 1'b0};
  logic [AW-1:0] m_rs1   [NS] = '{default: '0};
  logic [AW-1:0] m_rs2   [NS] = '{default: '0};
  bit            m_r1    [NS] = '{default: 1'b0};
  bit            m_r2    [NS] = '{default: 1'b0};
  int            m_seq   [NS] = '{default: 0};
  int            m_next_seq = 0;
  bit            m_offer = 1'b0;
  int            m_sel = 0;

  function automatic int oldest_ready(input int excl);
    int best;
    best = -1;
    for (int i = 0; i < NS; i++)
      if (m_valid[i] && m_r1[i] && m_r2[i] && i != excl && (best < 0 || m_seq[i] < m_seq[best]))
        best = i;
    return best;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < NS; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int n;
    n = 0;
    for (int i = 0; i < NS; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  function automatic bit m_dready();
    bit hazard;
    hazard = cdb_valid && ((!dispatch_rs1_ready && dispatch_rs1 == cdb_in) ||
                           (!dispatch_rs2_ready && dispatch_rs2 == cdb_in));
`ifdef RS_SCHED_CDB_BYPASS_EN
    hazard = 1'b0;
`endif
    return lowest_free() >= 0 && !flush && !hazard;
  endfunction

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
      m_offer = 1'b0;
      m_sel   = 0;
    end else begin
      int  k, first, nxt;
      bit  dfire, ifire;
      k     = lowest_free();
      dfire = dispatch_valid && m_dready();
      ifire = m_offer && issue_ready && !flush;
      first = oldest_ready(-1);
      nxt   = oldest_ready(m_sel);
      if (flush) begin
        for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
        m_offer = 1'b0;
      end else begin
        if (!m_offer) begin
          if (first >= 0) begin
            m_offer = 1'b1;
            m_sel   = first;
          end
        end else if (ifire) begin
          m_valid[m_sel] = 1'b0;
          if (nxt >= 0) m_sel = nxt;
          else          m_offer = 1'b0;
        end
        for (int i = 0; i < NS; i++) begin
          if (cdb_valid && m_valid[i]) begin
            if (m_rs1[i] == cdb_in) m_r1[i] = 1'b1;
            if (m_rs2[i] == cdb_in) m_r2[i] = 1'b1;
          end
        end
        if (dfire) begin
          m_valid[k] = 1'b1;
          m_rs1[k]   = dispatch_rs1;
          m_rs2[k]   = dispatch_rs2;
          m_r1[k]    = dispatch_rs1_ready;
          m_r2[k]    = dispatch_rs2_ready;
`ifdef RS_SCHED_CDB_BYPASS_EN
          if (cdb_valid && dispatch_rs1 == cdb_in) m_r1[k] = 1'b1;
          if (cdb_valid && dispatch_rs2 == cdb_in) m_r2[k] = 1'b1;
`endif
          m_seq[k]   = m_next_seq;
          m_next_seq++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (!reset) begin
      bit exp_wen, exp_clr;
      exp_wen = dispatch_valid && m_dready();
      exp_clr = m_offer && issue_ready && !flush;
      chk("m_issue_valid", issue_valid, m_offer);
      chk("m_issue_sel", issue_sel, m_sel);
      chk("m_occupancy", occupancy, m_count());
      chk("m_dispatch_ready", dispatch_ready, m_dready());
      chk("m_write_en", stat_write_en, exp_wen);
      if (exp_wen) chk("m_write_sel", stat_write_sel, lowest_free());
      chk("m_clear", stat_clear, exp_clr);
      if (exp_clr) chk("m_clear_sel", stat_clear_sel, m_sel);
      chk("m_flush", stat_flush, flush);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    dispatch_valid = 0; dispatch_rs1 = '0; dispatch_rs2 = '0;
    dispatch_rs1_ready = 0; dispatch_rs2_ready = 0;
    cdb_valid = 0; cdb_in = '0; issue_ready = 0; flush = 0;
  endtask

  task automatic disp(input logic [AW-1:0] t1, input logic r1, input logic [AW-1:0] t2, input logic r2);
    dispatch_valid = 1; dispatch_rs1 = t1; dispatch_rs1_ready = r1;
    dispatch_rs2 = t2; dispatch_rs2_ready = r2;
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_sel", issue_sel, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_dispatch_ready", dispatch_ready, 1);

    // single ready dispatch, offered one cycle after allocation
    disp(5, 1, 6, 1);
    #1;
    chk("t1_write_en", stat_write_en, 1);
    chk("t1_write_sel", stat_write_sel, 0);
    cyc(); dispatch_valid = 0; #1;
    chk("t1_not_yet_offered", issue_valid, 0);
    cyc(); #1;
    chk("t1_issue_valid", issue_valid, 1);
    chk("t1_issue_sel", issue_sel, 0);
    issue_ready = 1; #1;
    chk("t1_clear", stat_clear, 1);
    chk("t1_clear_sel", stat_clear_sel, 0);
    cyc(); issue_ready = 0; #1;
    chk("t1_back_idle", issue_valid, 0);
    chk("t1_occ_zero", occupancy, 0);

    // fill the bank waiting on tag 9, then wake everything at once
    for (int k = 0; k < NS; k++) begin
      disp(9, 0, 3, 1);
      #1;
      chk("t2_fill_sel", stat_write_sel, k);
      cyc();
    end
    #1;
    chk("t2_full_ready", dispatch_ready, 0);
    chk("t2_full_wen", stat_write_en, 0);
    chk("t2_full_occ", occupancy, 4);
    dispatch_valid = 0; cdb_valid = 1; cdb_in = 9; issue_ready = 1;
    cyc(); cdb_valid = 0; #1;
    chk("t2_woken_idle", issue_valid, 0);
    cyc(); #1;
    chk("t2_first_valid", issue_valid, 1);
    chk("t2_first_sel", issue_sel, 0);
    for (int k = 1; k < NS; k++) begin
      cyc(); #1;
      chk("t2_order_sel", issue_sel, k);
      if (k == 1) begin
        chk("t2_occ_after_one", occupancy, 3);
        chk("t2_ready_after_one", dispatch_ready, 1);
      end
    end
    cyc(); issue_ready = 0; #1;
    chk("t2_drained_valid", issue_valid, 0);
    chk("t2_drained_occ", occupancy, 0);

    // an older station waking during a stalled offer does not preempt it
    disp(20, 0, 1, 1); cyc();
    disp(21, 0, 1, 1); cyc();
    disp(22, 1, 1, 1); cyc();
    dispatch_valid = 0; cyc(); #1;
    chk("t3_offer_valid", issue_valid, 1);
    chk("t3_offer_sel", issue_sel, 2);
    cdb_valid = 1; cdb_in = 21;
    cyc(); cdb_valid = 0; #1;
    chk("t3_hold_sel_a", issue_sel, 2);
    cyc(); #1;
    chk("t3_hold_sel_b", issue_sel, 2);
    issue_ready = 1; #1;
    chk("t3_clear_sel", stat_clear_sel, 2);
    cyc(); #1;
    chk("t3_next_valid", issue_valid, 1);
    chk("t3_next_sel", issue_sel, 1);
    cyc(); issue_ready = 0; #1;
    chk("t3_idle_valid", issue_valid, 0);
    chk("t3_left_occ", occupancy, 1);

    // flush while offering with three valid stations
    disp(30, 1, 1, 1); cyc();
    disp(31, 1, 1, 1); cyc();
    dispatch_valid = 0; #1;
    chk("t5_pre_valid", issue_valid, 1);
    chk("t5_pre_sel", issue_sel, 1);
    chk("t5_pre_occ", occupancy, 3);
    flush = 1; issue_ready = 1; disp(32, 1, 1, 1); #1;
    chk("t5_stat_flush", stat_flush, 1);
    chk("t5_dready_low", dispatch_ready, 0);
    chk("t5_wen_low", stat_write_en, 0);
    chk("t5_clear_low", stat_clear, 0);
    cyc(); idle_in(); #1;
    chk("t5_post_valid", issue_valid, 0);
    chk("t5_post_occ", occupancy, 0);
    chk("t5_post_dready", dispatch_ready, 1);

    // dispatch of a pending tag in the same cycle as its broadcast
    disp(12, 0, 13, 1); cdb_valid = 1; cdb_in = 12; #1;
`ifdef RS_SCHED_CDB_BYPASS_EN
    chk("t4_bypass_wen", stat_write_en, 1);
    chk("t4_bypass_sel", stat_write_sel, 0);
    cyc(); dispatch_valid = 0; cdb_valid = 0;
    cyc(); #1;
`else
    chk("t4_block_dready", dispatch_ready, 0);
    chk("t4_block_wen", stat_write_en, 0);
    cyc(); cdb_valid = 0; #1;
    chk("t4_retry_wen", stat_write_en, 1);
    chk("t4_retry_sel", stat_write_sel, 0);
    cyc(); dispatch_valid = 0; cdb_valid = 1; cdb_in = 12;
    cyc(); cdb_valid = 0;
    cyc(); #1;
`endif
    chk("t4_offer_valid", issue_valid, 1);
    chk("t4_offer_sel", issue_sel, 0);

    // asynchronous reset in the middle of an offer
    reset = 1'b1; #1;
    chk("t6_async_valid", issue_valid, 0);
    chk("t6_async_occ", occupancy, 0);
    chk("t6_async_dready", dispatch_ready, 1);
    cyc(); reset = 1'b0;
    disp(40, 1, 41, 1);
    cyc(); dispatch_valid = 0; issue_ready = 1;
    repeat (3) cyc();
    idle_in();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
